bcd2bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter. Inverse of the binary-to-BCD display path.

---
 rtl/bcd2bin_seq.sv | 152 +++++++++++++++
 tb/tb_bcd2bin_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// 3-digit BCD (0-399) to binary via reverse double-dabble, one iteration per clock; DONE 9 edges after START edge.
// START is ignored while BUSY; `BCD2BIN_RANGE_CHECK_EN adds the ERR digit/overflow flag (else ERR is tied low).
module bcd2bin_seq #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [7:0] BIN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [18:0] work_q, work_d;
  logic [7:0]  bin_q, bin_d;
  logic        done_q, done_d;
  logic        load_en;
  logic        fin_en;
  logic [18:0] work_shr;
  logic [18:0] work_step;

  // Work register layout: [18:17] hundreds, [16:13] tens, [12:9] ones, [8:0] binary result.
  always_comb begin
    work_shr  = work_q >> 1;
    work_step = work_shr;
    if (work_shr[16:13] >= 4'd8) begin
      work_step[16:13] = work_shr[16:13] - 4'd3;
    end
    if (work_shr[12:9] >= 4'd8) begin
      work_step[12:9] = work_shr[12:9] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    fin_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          load_en = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_ITER) begin
          fin_en  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (START) begin
          load_en = 1'b1;
        end else if (DONE_PULSE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load_en) begin
      state_d = ST_SHIFT;
    end
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    done_d = done_q;
    if (load_en) begin
      work_d = {HUNDREDS, TENS, ONES, 9'b0};
      cnt_d  = 4'd0;
      done_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      work_d = work_step;
      cnt_d  = cnt_q + 4'd1;
      if (fin_en) begin
        bin_d  = work_step[7:0];
        done_d = 1'b1;
      end
    end else if (state_q == ST_FIN && DONE_PULSE) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      work_q  <= 19'd0;
      bin_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD2BIN_RANGE_CHECK_EN
  logic err_cap_q, err_cap_d;
  logic err_q, err_d;

  // Digit error is latched with the operands; overflow is only known at completion.
  always_comb begin
    err_cap_d = err_cap_q;
    err_d     = err_q;
    if (load_en) begin
      err_cap_d = (TENS > 4'd9) | (ONES > 4'd9);
    end
    if (fin_en) begin
      err_d = err_cap_q | work_step[8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cap_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_cap_q <= err_cap_d;
      err_q     <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_res_msb;
  assign unused_res_msb = work_step[8];
  assign ERR            = 1'b0;
`endif

  assign BIN  = bin_q;
  assign BUSY = (state_q == ST_SHIFT);
  assign DONE = done_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: pulsed-DONE instance plus a level-DONE instance.
module tb_bcd2bin_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_lvl;
  logic [1:0] hun;
  logic [3:0] ten;
  logic [3:0] one;
  logic [7:0] bin_p, bin_l;
  logic       busy_p, busy_l;
  logic       done_p, done_l;
  logic       err_p, err_l;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BCD2BIN_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd2bin_seq #(.DONE_PULSE(1'b1)) dut (
    .CLK(clk), .RST(rst), .START(start), .HUNDREDS(hun), .TENS(ten), .ONES(one),
    .BIN(bin_p), .BUSY(busy_p), .DONE(done_p), .ERR(err_p)
  );

  bcd2bin_seq #(.DONE_PULSE(1'b0)) dut_lvl (
    .CLK(clk), .RST(rst), .START(start_lvl), .HUNDREDS(hun), .TENS(ten), .ONES(one),
    .BIN(bin_l), .BUSY(busy_l), .DONE(done_l), .ERR(err_l)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load on the pulsed instance, then count edges until DONE (bounded).
  task automatic conv(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                      output int lat);
    hun   = h;
    ten   = t;
    one   = o;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", 16'(busy_p), 16'd1);
    chk("load_done", 16'(done_p), 16'd0);
    lat = 0;
    while (!done_p && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int busy_cnt;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_lvl = 1'b0;
    hun       = 2'd0;
    ten       = 4'd0;
    one       = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_bin", 16'(bin_p), 16'd0);
    chk("rst_busy", 16'(busy_p), 16'd0);
    chk("rst_done", 16'(done_p), 16'd0);
    chk("rst_err", 16'(err_p), 16'd0);
    chk("rst_done_lvl", 16'(done_l), 16'd0);

    // 255: BUSY for exactly 9 sampled cycles, DONE after edge k+9
    hun = 2'd2; ten = 4'd5; one = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    lat      = 0;
    while (!done_p && lat < 20) begin
      if (busy_p) busy_cnt++;
      tick();
      lat++;
    end
    chk("t1_busy_cycles", 16'(busy_cnt), 16'd9);
    chk("t1_latency", 16'(lat), 16'd9);
    chk("t1_bin", 16'(bin_p), 16'd255);
    chk("t1_err", 16'(err_p), 16'd0);
    chk("t1_busy_at_done", 16'(busy_p), 16'd0);
    tick();
    chk("t1_done_pulse", 16'(done_p), 16'd0);
    chk("t1_bin_hold", 16'(bin_p), 16'd255);

    // 0 then back-to-back 128 issued in the FIN cycle
    conv(2'd0, 4'd0, 4'd0, lat);
    chk("t2a_latency", 16'(lat), 16'd9);
    chk("t2a_bin", 16'(bin_p), 16'd0);
    conv(2'd1, 4'd2, 4'd8, lat);
    chk("t2b_latency", 16'(lat), 16'd9);
    chk("t2b_bin", 16'(bin_p), 16'd128);

    // START and digits churned while busy must not disturb the captured 073
    tick();
    hun = 2'd0; ten = 4'd7; one = 4'd3; start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      start = (i % 2 == 0);
      hun   = 2'(i);
      ten   = 4'(i + 1);
      one   = 4'(9 - i);
      tick();
    end
    start = 1'b0;
    chk("t3_done", 16'(done_p), 16'd1);
    chk("t3_bin", 16'(bin_p), 16'd73);
    tick();
    chk("t3_idle_busy", 16'(busy_p), 16'd0);
    chk("t3_idle_done", 16'(done_p), 16'd0);

    // Reset in the 4th SHIFT cycle, then a clean conversion
    hun = 2'd3; ten = 4'd3; one = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t4_mid_busy", 16'(busy_p), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", 16'(busy_p), 16'd0);
    chk("t4_rst_done", 16'(done_p), 16'd0);
    chk("t4_rst_bin", 16'(bin_p), 16'd0);
    chk("t4_rst_err", 16'(err_p), 16'd0);
    conv(2'd0, 4'd4, 4'd2, lat);
    chk("t4_latency", 16'(lat), 16'd9);
    chk("t4_bin", 16'(bin_p), 16'd42);

    // Overflow and bad-digit flagging
    tick();
    conv(2'd3, 4'd9, 4'd9, lat);
    chk("t5a_bin", 16'(bin_p), 16'h8F);
    chk("t5a_err", 16'(err_p), 16'(RC));
    tick();
    conv(2'd0, 4'd1, 4'hA, lat);
    chk("t5b_latency", 16'(lat), 16'd9);
    chk("t5b_err", 16'(err_p), 16'(RC));
    tick();
    conv(2'd2, 4'd5, 4'd5, lat);
    chk("t5c_bin", 16'(bin_p), 16'd255);
    chk("t5c_err", 16'(err_p), 16'd0);
    tick();

    // Level DONE: held until the next accepted START edge
    hun = 2'd0; ten = 4'd9; one = 4'd9; start_lvl = 1'b1;
    tick();
    start_lvl = 1'b0;
    lat = 0;
    while (!done_l && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6_latency", 16'(lat), 16'd9);
    chk("t6_bin", 16'(bin_l), 16'd99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_done_held", 16'(done_l), 16'd1);
    end
    hun = 2'd0; ten = 4'd0; one = 4'd5; start_lvl = 1'b1;
    tick();
    start_lvl = 1'b0;
    chk("t6_done_clr", 16'(done_l), 16'd0);
    chk("t6_busy", 16'(busy_l), 16'd1);
    chk("t6_bin_hold", 16'(bin_l), 16'd99);
    lat = 0;
    while (!done_l && lat < 20) begin
      tick();
      lat++;
    end
    chk("t6b_latency", 16'(lat), 16'd9);
    chk("t6b_bin", 16'(bin_l), 16'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
